cipher_stream: RTL
==================

# cipher_stream

Parametrised, iterative, keyed encrypt/decrypt engine for the hashing/cipher datapath. It processes one DATA_W-bit word per transaction over ROUNDS clocked rounds, with a runtime key and a per-word mode bit. It sits between a valid/ready word source and a valid/ready sink, replacing the fixed 8-bit combinational encrypt stage. Decrypt is the exact inverse of encrypt for the same key and ROUNDS.

## Interface
- DATA_W, 8: word and key width; legal range 4..32.
- ROUNDS, 4: rounds per word; legal range 1..16.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- key_in  input  DATA_W  key value
- key_load  input  1  loads key_in into the key register, accepted in IDLE only
- in_data  input  DATA_W  plaintext (encrypt) or ciphertext (decrypt)
- in_mode  input  1  0 = encrypt, 1 = decrypt; sampled with in_data
- in_valid  input  1  source has a word
- in_ready  output  1  engine accepts a word this cycle
- out_data  output  DATA_W  result word, stable while out_valid
- out_valid  output  1  result available
- out_ready  input  1  sink accepts result
- busy  output  1  high in RUN or DONE

## Operation
- Arithmetic is mod 2^DATA_W. rotl/rotr rotate by the stated amount within DATA_W bits.
- Round key: k_r = rotl(key, r mod DATA_W) XOR r, where r is zero-extended, for r = 0..ROUNDS-1.
- Encrypt round r, with r ascending from 0: a = x XOR k_r; b = a + k_r; x = rotl(b, 1).
- Decrypt round r, with r descending from ROUNDS-1: b = rotr(x, 1); a = b - k_r; x = a XOR k_r.
- FSM IDLE -> RUN -> DONE -> IDLE:
  - IDLE: in_ready = !key_load. On in_valid && in_ready, capture in_data into the state register, latch in_mode, and load the round counter with 0 (encrypt) or ROUNDS-1 (decrypt). Go to RUN.
  - RUN: apply one round per cycle and step the counter up (encrypt) or down (decrypt). After the ROUNDS-th round, go to DONE.
  - DONE: out_valid = 1 and out_data = state register. On out_ready, go to IDLE.
- Key register:
  - Written only in IDLE on key_load.
  - key_load in RUN or DONE is ignored. The word in flight always uses the key captured before its acceptance.
  - key_load and in_valid in the same IDLE cycle: the key loads, the word is not accepted (in_ready = 0), and the word is accepted on a later cycle with the new key.
- in_ready is 0 in RUN and DONE; a source holding in_valid waits.
- ROUNDS = 1: RUN lasts exactly one cycle.
- Reset (asynchronous, any state, including mid-RUN):
  - state goes to IDLE; key, state register and counter clear to 0.
  - out_valid = 0, busy = 0, out_data = 0, in_ready = 1 (since key_load is don't-care at reset release, in_ready = !key_load).
  - The in-flight word is discarded with no output.

## Timing
- Acceptance at rising edge N → out_valid high after edge N+ROUNDS, i.e. latency ROUNDS cycles.
- Without back-pressure: throughput one word per ROUNDS+2 cycles (accept, ROUNDS rounds, DONE handshake, IDLE).
- out_valid stays high and out_data stays stable until the out_ready handshake. out_valid drops on the edge that completes the handshake.
- busy rises on the acceptance edge and falls on the output-handshake edge.
- No combinational path from in_valid to in_ready; in_ready depends only on state and key_load.

## Test plan
- DATA_W=8, ROUNDS=4, key 0x00, encrypt 0x01 → out_data 0x3C exactly 4 cycles after acceptance; then decrypt 0x3C → 0x01.
- DATA_W=8, ROUNDS=4, key 0xA5, encrypt 0x00 → 0x99. Same key with ROUNDS=2, key 0x00, encrypt 0x01 → 0x08. ROUNDS=1, key 0x00, encrypt 0x01 → 0x02.
- Round-trip on 256 random words × random keys × DATA_W ∈ {8, 16} → decrypt(encrypt(x)) == x. With out_ready held low for 0–10 random cycles: out_data stable, in_ready = 0, no word lost or duplicated.
- key_load 0x00 asserted with in_valid in IDLE → in_ready = 0 that cycle, key updates, word accepted next cycle. key_load 0xFF pulsed mid-RUN → current result still uses the old key, and the next word also uses the old key.
- Assert rst_n low during RUN round 2 → out_valid, busy and key go to 0 immediately; after release in_ready = 1, no spurious output, and the next word with key 0x00 encrypts 0x01 → 0x3C.

Source files
------------

// File: rtl/cipher_stream.sv
// Iterative keyed stream cipher: one word per transaction, one add/xor/rotate round per clock.
// Decrypt walks the same round keys in reverse and undoes each round exactly.
module cipher_stream #(
    parameter int DATA_W = 8,
    parameter int ROUNDS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] key_in,
    input  logic              key_load,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_mode,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);
    localparam int CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e            state_q;
    logic [DATA_W-1:0] key_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] rkey;
    logic [DATA_W-1:0] enc_sum;
    logic [CNT_W-1:0]  cnt_q;
    logic              mode_q;
    logic              last_round;

    function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] v, input int unsigned s);
        logic [2*DATA_W-1:0] t;
        t = {v, v} << s;
        return t[2*DATA_W-1:DATA_W];
    endfunction

    always_comb begin
        rkey    = rotl(key_q, 32'(cnt_q) % DATA_W) ^ DATA_W'(cnt_q);
        enc_sum = (data_q ^ rkey) + rkey;
        if (mode_q)
            data_d = ({data_q[0], data_q[DATA_W-1:1]} - rkey) ^ rkey;
        else
            data_d = {enc_sum[DATA_W-2:0], enc_sum[DATA_W-1]};
        last_round = mode_q ? (cnt_q == '0) : (cnt_q == CNT_W'(ROUNDS - 1));
    end

    // Key loading takes priority over accepting a word, so in_ready never depends on in_valid.
    assign in_ready  = (state_q == IDLE) && !key_load;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (key_load) begin
                        key_q <= key_in;
                    end else if (in_valid) begin
                        data_q  <= in_data;
                        mode_q  <= in_mode;
                        cnt_q   <= in_mode ? CNT_W'(ROUNDS - 1) : '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    data_q <= data_d;
                    if (last_round)
                        state_q <= DONE;
                    else
                        cnt_q <= mode_q ? cnt_q - CNT_W'(1) : cnt_q + CNT_W'(1);
                end
                DONE: begin
                    if (out_ready)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
